mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Parametrised multicycle control unit for the MIPS datapath. It is the next generation of the processor control FSM. It adds a reset-time stack-pointer initialisation, configurable memory wait states, a start/done handshake with the mult/div unit, and three exception paths. All datapath select and enable signals are Moore outputs decoded from the state register.

## Interface
- `MEM_WAIT`, default 1: memory read latency in cycles (≥1); sets the length of the fetch and load states.
- `SP_INIT`, default 227: value written to `$29` after reset. The datapath drives this constant on `mem_to_reg`=0010.
- `VEC_BASE`, default 253: byte address of the exception vector table. Entries: +0 invalid opcode, +1 overflow, +2 divide-by-zero.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero`, `overflow` in 1 each: ALU flags.
- `md_done`, `div_zero` in 1 each: flags from the mult/div unit.
- `pc_write`, `pc_write_cond` out 1: PC enables.
- `pc_source` out 3: PC mux select. 000 ALU, 001 ALUOut, 010 jump target, 011 memory byte, 100 vector address.
- `I_or_D` out 1: memory address select. 0 = PC, 1 = ALUOut/vector.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `ir_write`, `reg_write`, `epc_write` out 1 each: register enables.
- `reg_dist` out 3: destination register select. 000 rt, 001 rd, 010 `$29`.
- `mem_to_reg` out 4: write-back select. 0000 ALUOut, 0001 MDR, 0010 SP_INIT, 0011 LO.
- `alu_src_a` out 2: 00 PC, 01 A.
- `alu_src_b` out 2: 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `alu_op` out 3: 000 pass A, 001 add, 010 sub, 011 and.
- `md_start` out 1: one-cycle start pulse to the mult/div unit.
- `div_or_mult` out 1: 1 = div.
- `rst_out` out 1: reset request to the datapath.
- `state_dbg` out 5: current state code.

## Operation
- States:
  - RESET
  - SP_SET
  - FETCH
  - DECODE
  - R_EXEC
  - R_WB
  - ADDI_EXEC
  - ADDI_WB
  - ADDR
  - LW_MEM
  - LW_WB
  - SW_MEM
  - BEQ
  - JUMP
  - MD_START
  - MD_WAIT
  - MD_WB
  - EXC
  - EXC_LOAD
- RESET: `rst_out`=1 and every other output is 0. While `reset`=1 the FSM stays in RESET. After `reset` falls, RESET→SP_SET.
- SP_SET: `reg_write`=1, `reg_dist`=010, `mem_to_reg`=0010. Then →FETCH.
- FETCH:
  - lasts MEM_WAIT cycles, counted by a wait counter; `mem_read`=1 and `I_or_D`=0 throughout.
  - last cycle only: `ir_write`=1 and `pc_write`=1, with `alu_src_a`=00, `alu_src_b`=01, `alu_op`=001, `pc_source`=000.
  - then →DECODE.
- DECODE: computes the branch target into ALUOut (`alu_src_a`=00, `alu_src_b`=11, `alu_op`=001). Dispatch:
  - opcode 0x00, funct 0x20/0x22/0x24 → R_EXEC
  - opcode 0x00, funct 0x18 (mult) or 0x1A (div) → MD_START
  - opcode 0x08 → ADDI_EXEC
  - opcode 0x23 or 0x2B → ADDR
  - opcode 0x04 → BEQ
  - opcode 0x02 → JUMP
  - anything else → EXC with cause 0
- R_EXEC: `alu_src_a`=01, `alu_src_b`=00. `alu_op` by funct: add 001, sub 010, and 011. →R_WB.
- R_WB: writes rd from ALUOut. If `overflow`=1 (add/sub only), no write and →EXC with cause 1.
- ADDI_EXEC→ADDI_WB: writes rt from ALUOut. On `overflow`, no write and →EXC with cause 1.
- ADDR→LW_MEM or SW_MEM:
  - LW_MEM lasts MEM_WAIT cycles, then LW_WB writes rt from MDR.
  - SW_MEM lasts 1 cycle with `mem_write`=1.
- BEQ: `alu_op`=010, `pc_write_cond`=1, `pc_source`=001. The datapath gates the write with `zero`.
- JUMP: `pc_write`=1, `pc_source`=010.
- MD_START: `md_start`=1 for exactly one cycle.
  - if `div_zero`=1 and the op is div → EXC with cause 2.
  - otherwise → MD_WAIT, which holds until `md_done`=1, then MD_WB.
  - MD_WB writes rd with `mem_to_reg`=0011.
  - `div_or_mult` stays valid from MD_START through MD_WB.
- EXC:
  - `epc_write`=1 (EPC ← PC−4, computed with `alu_op`=010, `alu_src_b`=01).
  - `I_or_D`=1, `pc_source`=100, `mem_read`=1.
  - the cause register selects vector VEC_BASE+cause.
  - holds for MEM_WAIT cycles, then →EXC_LOAD.
- EXC_LOAD: `pc_write`=1, `pc_source`=011 (PC ← zero-extended vector byte). Then →FETCH.
- Every terminal state (R_WB, ADDI_WB, LW_WB, SW_MEM, BEQ, JUMP, MD_WB, EXC_LOAD) returns to FETCH.

## Timing
- All outputs are combinational decodes of the registered state. No output depends on the inputs, except the next-state transition.
- Cycle counts with MEM_WAIT=1:
  - R-type 4 (FETCH, DECODE, R_EXEC, R_WB)
  - lw 5
  - sw 4
  - beq and j 3
  - mult/div 5 + wait
  - exception 2 + MEM_WAIT, counted from the detecting state
- Wait counter: width $clog2(MEM_WAIT+1). It clears on every state entry and never wraps.
- `reset` has priority in every state, including MD_WAIT and FETCH mid-wait. The next edge goes to RESET and the counter and cause register clear. A pending mult/div op is abandoned, with no further `md_start`.
- `md_done` arriving while not in MD_WAIT is ignored.

## Structure
- Package `mc_ctrl_pkg`:
  - state enum
  - encodings for `alu_op`, `pc_source`, `mem_to_reg`, `reg_dist`
  - opcode and funct constants
  - exception cause codes
- Sub-module `mc_wait_cnt` (parametrised down-counter with `done` flag), shared by the FETCH, LW_MEM and EXC waits.

## Test plan
- Hold `reset` 3 cycles, then release. Required: `rst_out`=1 during reset, then one SP_SET cycle with `reg_write`=1, `reg_dist`=010, `mem_to_reg`=0010, then FETCH.
- Drive opcode 0x00, funct 0x20 with MEM_WAIT=3. Required: FETCH lasts 3 cycles, `ir_write` asserts only in the 3rd, R_WB asserts `reg_write` with `reg_dist`=001.
- Drive addi with `overflow`=1. Required: no `reg_write`, EXC asserts `epc_write`, and EXC_LOAD asserts `pc_write` with `pc_source`=011 and vector 254.
- Drive div with `md_done` delayed 33 cycles. Required: `md_start` is a single pulse, the FSM stays in MD_WAIT, and MD_WB asserts `mem_to_reg`=0011. Repeat with `div_zero`=1: required vector 255.
- Drive opcode 0x3F. Required: DECODE→EXC with vector 253.
- Assert `reset` mid-MD_WAIT. Required: RESET on the next edge with all outputs 0 except `rst_out`.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit.
// - State codes. These are what state_dbg shows.
// - Encodings of the datapath select buses.
// - Opcode and funct constants.
// - Exception cause codes.
// - A helper that maps an R-type funct field to an ALU operation.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef logic [4:0] state_t;

  localparam state_t S_RESET     = 5'd0;
  localparam state_t S_SP_SET    = 5'd1;
  localparam state_t S_FETCH     = 5'd2;
  localparam state_t S_DECODE    = 5'd3;
  localparam state_t S_R_EXEC    = 5'd4;
  localparam state_t S_R_WB      = 5'd5;
  localparam state_t S_ADDI_EXEC = 5'd6;
  localparam state_t S_ADDI_WB   = 5'd7;
  localparam state_t S_ADDR      = 5'd8;
  localparam state_t S_LW_MEM    = 5'd9;
  localparam state_t S_LW_WB     = 5'd10;
  localparam state_t S_SW_MEM    = 5'd11;
  localparam state_t S_BEQ       = 5'd12;
  localparam state_t S_JUMP      = 5'd13;
  localparam state_t S_MD_START  = 5'd14;
  localparam state_t S_MD_WAIT   = 5'd15;
  localparam state_t S_MD_WB     = 5'd16;
  localparam state_t S_EXC       = 5'd17;
  localparam state_t S_EXC_LOAD  = 5'd18;

  // ALU operation
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  // PC source mux
  localparam logic [2:0] PCS_ALU    = 3'b000;
  localparam logic [2:0] PCS_ALUOUT = 3'b001;
  localparam logic [2:0] PCS_JUMP   = 3'b010;
  localparam logic [2:0] PCS_MEMB   = 3'b011;
  localparam logic [2:0] PCS_VEC    = 3'b100;

  // Write-back source
  localparam logic [3:0] M2R_ALUOUT = 4'b0000;
  localparam logic [3:0] M2R_MDR    = 4'b0001;
  localparam logic [3:0] M2R_SPINIT = 4'b0010;
  localparam logic [3:0] M2R_LO     = 4'b0011;

  // Destination register
  localparam logic [2:0] RD_RT = 3'b000;
  localparam logic [2:0] RD_RD = 3'b001;
  localparam logic [2:0] RD_SP = 3'b010;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_A    = 2'b01;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  // Exception causes. Each one is the offset into the vector table.
  localparam logic [1:0] CAUSE_INV  = 2'd0;
  localparam logic [1:0] CAUSE_OVF  = 2'd1;
  localparam logic [1:0] CAUSE_DIVZ = 2'd2;

  function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_wait_cnt.sv
// ---------------------------------------------------------------------------
// mc_wait_cnt
// Down-counter that times the memory waits in FETCH, LW_MEM and EXC.
// On every state entry the counter is loaded with MEM_WAIT-1.
// It then counts down once per cycle and stops at zero, so it never wraps.
// done is high in the last cycle of a MEM_WAIT-long state.
// When MEM_WAIT=1, done is high in the very first cycle.
//   clock  in  : rising-edge clock
//   reset  in  : synchronous, active-high; clears the count
//   load   in  : high on the cycle before a state change
//   done   out : remaining count is zero
// ---------------------------------------------------------------------------
module mc_wait_cnt #(
  parameter int MEM_WAIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CNT_W = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_WAIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle control unit for the MIPS datapath.
// All select and enable outputs are Moore decodes of the registered state.
// The registered state includes a few per-instruction flags latched in
// DECODE and EXEC. The inputs only steer the next-state transition.
//
// Parameters
//   MEM_WAIT  : memory read latency; sets the length of FETCH, LW_MEM and EXC
//   SP_INIT   : value written to $29 after reset (driven on sp_value)
//   VEC_BASE  : byte address of the exception vector table
//
// Ports
//   clock, reset           : clock; synchronous active-high reset
//   opcode, funct          : IR[31:26], IR[5:0]
//   zero, overflow         : ALU flags (zero is only used by the datapath)
//   md_done, div_zero      : mult/div unit flags
//   pc_write, pc_write_cond, pc_source, I_or_D, mem_read, mem_write,
//   ir_write, reg_write, epc_write, reg_dist, mem_to_reg,
//   alu_src_a, alu_src_b, alu_op, md_start, div_or_mult, rst_out
//                          : datapath controls
//   vec_addr               : VEC_BASE+cause during EXC/EXC_LOAD, else 0
//   sp_value               : SP_INIT during SP_SET, else 0
//   state_dbg              : current state code
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int SP_INIT  = 227,
  parameter int VEC_BASE = 253
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        overflow,
  input  logic        md_done,
  input  logic        div_zero,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [2:0]  pc_source,
  output logic        I_or_D,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        epc_write,
  output logic [2:0]  reg_dist,
  output logic [3:0]  mem_to_reg,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        md_start,
  output logic        div_or_mult,
  output logic        rst_out,
  output logic [31:0] vec_addr,
  output logic [31:0] sp_value,
  output logic [4:0]  state_dbg
);

  state_t     state, state_nxt;
  logic [1:0] cause_q, cause_nxt;
  logic [2:0] r_op_q;     // ALU op for the R-type in flight
  logic       ovf_chk_q;  // R-type is add/sub, so overflow traps
  logic       is_div_q;   // mult/div op in flight is a div
  logic       ovf_q;      // overflow captured during the EXEC cycle
  logic       wait_done;
  logic       wait_load;

  // The zero flag only gates pc_write_cond inside the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  // Reload the wait counter whenever the state changes. This gives each
  // waiting state a fresh count.
  assign wait_load = (state_nxt != state);

  mc_wait_cnt #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clock (clock),
    .reset (reset),
    .load  (wait_load),
    .done  (wait_done)
  );

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    case (state)
      S_RESET:  state_nxt = S_SP_SET;
      S_SP_SET: state_nxt = S_FETCH;
      S_FETCH:  if (wait_done) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
              state_nxt = S_R_EXEC;
            end else if (funct == FN_MULT || funct == FN_DIV) begin
              state_nxt = S_MD_START;
            end else begin
              state_nxt = S_EXC;
              cause_nxt = CAUSE_INV;
            end
          end
          OP_ADDI:      state_nxt = S_ADDI_EXEC;
          OP_LW, OP_SW: state_nxt = S_ADDR;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            state_nxt = S_EXC;
            cause_nxt = CAUSE_INV;
          end
        endcase
      end
      S_R_EXEC:    state_nxt = S_R_WB;
      S_ADDI_EXEC: state_nxt = S_ADDI_WB;
      S_R_WB, S_ADDI_WB: begin
        if (ovf_q) begin
          state_nxt = S_EXC;
          cause_nxt = CAUSE_OVF;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_ADDR:   state_nxt = (opcode == OP_LW) ? S_LW_MEM : S_SW_MEM;
      S_LW_MEM: if (wait_done) state_nxt = S_LW_WB;
      S_MD_START: begin
        if (div_zero && is_div_q) begin
          state_nxt = S_EXC;
          cause_nxt = CAUSE_DIVZ;
        end else begin
          state_nxt = S_MD_WAIT;
        end
      end
      S_MD_WAIT: if (md_done) state_nxt = S_MD_WB;
      S_EXC:     if (wait_done) state_nxt = S_EXC_LOAD;
      S_LW_WB, S_SW_MEM, S_BEQ, S_JUMP, S_MD_WB, S_EXC_LOAD:
        state_nxt = S_FETCH;
      default:   state_nxt = S_RESET;
    endcase
  end

  // ---- state register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_RESET;
      cause_q   <= CAUSE_INV;
      r_op_q    <= ALU_PASS;
      ovf_chk_q <= 1'b0;
      is_div_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      // Latch the instruction flavour once, so that the EXEC/MD outputs
      // stay pure state decodes.
      if (state == S_DECODE) begin
        r_op_q    <= funct_alu_op(funct);
        ovf_chk_q <= (funct != FN_AND);
        is_div_q  <= (funct == FN_DIV);
      end
      // The ALU raises overflow while it computes, so capture it here. The
      // following write-back state can then suppress the write.
      if (state == S_R_EXEC) begin
        ovf_q <= overflow & ovf_chk_q;
      end else if (state == S_ADDI_EXEC) begin
        ovf_q <= overflow;
      end
    end
  end

  // ---- output decode ----
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    I_or_D        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    epc_write     = 1'b0;
    reg_dist      = RD_RT;
    mem_to_reg    = M2R_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_PASS;
    md_start      = 1'b0;
    div_or_mult   = 1'b0;
    rst_out       = 1'b0;
    vec_addr      = 32'd0;
    sp_value      = 32'd0;
    case (state)
      S_RESET: rst_out = 1'b1;
      S_SP_SET: begin
        reg_write  = 1'b1;
        reg_dist   = RD_SP;
        mem_to_reg = M2R_SPINIT;
        sp_value   = 32'(SP_INIT);
      end
      S_FETCH: begin
        mem_read = 1'b1;
        // IR and PC update only once the memory data is valid.
        if (wait_done) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_4;
          alu_op    = ALU_ADD;
          pc_source = PCS_ALU;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_IMM2;
        alu_op    = ALU_ADD;
      end
      S_R_EXEC: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = r_op_q;
      end
      S_R_WB: begin
        reg_write = ~ovf_q;
        reg_dist  = RD_RD;
      end
      S_ADDI_EXEC, S_ADDR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_ADDI_WB: reg_write = ~ovf_q;
      S_LW_MEM: begin
        mem_read = 1'b1;
        I_or_D   = 1'b1;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_SW_MEM: begin
        mem_write = 1'b1;
        I_or_D    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = SRCA_A;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
      end
      S_MD_START: begin
        md_start    = 1'b1;
        div_or_mult = is_div_q;
      end
      S_MD_WAIT: div_or_mult = is_div_q;
      S_MD_WB: begin
        reg_write   = 1'b1;
        reg_dist    = RD_RD;
        mem_to_reg  = M2R_LO;
        div_or_mult = is_div_q;
      end
      S_EXC: begin
        // EPC <- PC-4, while the vector byte is read from VEC_BASE+cause.
        epc_write = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_4;
        alu_op    = ALU_SUB;
        I_or_D    = 1'b1;
        mem_read  = 1'b1;
        pc_source = PCS_VEC;
        vec_addr  = 32'(VEC_BASE + int'(cause_q));
      end
      S_EXC_LOAD: begin
        pc_write  = 1'b1;
        pc_source = PCS_MEMB;
        vec_addr  = 32'(VEC_BASE + int'(cause_q));
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm with MEM_WAIT=3.
// Each instruction is expanded into the list of per-cycle output bundles it
// should produce. The bench then compares the DUT outputs against that list,
// one cycle at a time. md_done is scheduled in the same list: it is pulsed
// at random while the DUT should not be waiting, and raised after the chosen
// delay inside the mult/div wait.
module tb_mc_ctrl_fsm;

  localparam int MW  = 3;
  localparam int VEC = 253;
  localparam int SPI = 227;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ADDI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_MULT = 8, K_DIV = 9,
                 K_BADOP = 10, K_BADFN = 11;

  typedef struct packed {
    logic        rst_out;
    logic        pc_write;
    logic        pc_write_cond;
    logic [2:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        epc_write;
    logic [2:0]  reg_dist;
    logic [3:0]  mem_to_reg;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        md_start;
    logic        div_or_mult;
    logic [31:0] vec_addr;
    logic [31:0] sp_value;
  } outs_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0, funct = '0;
  logic        zero = 1'b0, overflow = 1'b0, md_done = 1'b0, div_zero = 1'b0;
  logic        pc_write, pc_write_cond, I_or_D, mem_read, mem_write;
  logic        ir_write, reg_write, epc_write, md_start, div_or_mult, rst_out;
  logic [2:0]  pc_source, reg_dist, alu_op;
  logic [3:0]  mem_to_reg;
  logic [1:0]  alu_src_a, alu_src_b;
  logic [31:0] vec_addr, sp_value;
  logic [4:0]  state_dbg;
  outs_t       act;

  int n_checks = 0;
  int n_fail   = 0;
  int forced_op = -1;
  outs_t expq[$];
  bit    mdq[$];

  mc_ctrl_fsm #(.MEM_WAIT(MW), .SP_INIT(SPI), .VEC_BASE(VEC)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow), .md_done(md_done), .div_zero(div_zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .I_or_D(I_or_D), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .epc_write(epc_write),
    .reg_dist(reg_dist), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .md_start(md_start),
    .div_or_mult(div_or_mult), .rst_out(rst_out), .vec_addr(vec_addr),
    .sp_value(sp_value), .state_dbg(state_dbg)
  );

  assign act = {rst_out, pc_write, pc_write_cond, pc_source, I_or_D, mem_read,
                mem_write, ir_write, reg_write, epc_write, reg_dist, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, md_start, div_or_mult, vec_addr,
                sp_value};

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit noise();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic void push(input outs_t o, input bit md);
    expq.push_back(o);
    mdq.push_back(md);
  endfunction

  function automatic void gen_fetch();
    outs_t o;
    for (int i = 0; i < MW; i++) begin
      o = '0;
      o.mem_read = 1'b1;
      if (i == MW - 1) begin
        o.ir_write = 1'b1; o.pc_write = 1'b1;
        o.alu_src_b = 2'b01; o.alu_op = 3'b001;
      end
      push(o, noise());
    end
  endfunction

  function automatic void gen_decode();
    outs_t o = '0;
    o.alu_src_b = 2'b11; o.alu_op = 3'b001;
    push(o, noise());
  endfunction

  function automatic void gen_exc(input int cause);
    outs_t o;
    for (int i = 0; i < MW; i++) begin
      o = '0;
      o.epc_write = 1'b1; o.i_or_d = 1'b1; o.mem_read = 1'b1;
      o.pc_source = 3'b100; o.alu_op = 3'b010; o.alu_src_b = 2'b01;
      o.vec_addr = 32'(VEC + cause);
      push(o, noise());
    end
    o = '0;
    o.pc_write = 1'b1; o.pc_source = 3'b011; o.vec_addr = 32'(VEC + cause);
    push(o, noise());
  endfunction

  task automatic do_reset(input int n);
    outs_t rv, sv;
    rv = '0; rv.rst_out = 1'b1;
    sv = '0; sv.reg_write = 1'b1; sv.reg_dist = 3'b010;
    sv.mem_to_reg = 4'b0010; sv.sp_value = 32'(SPI);
    reset = 1'b1; md_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk($sformatf("reset[%0d]", i), 128'(act), 128'(rv));
      chk($sformatf("reset_dbg[%0d]", i), 128'(state_dbg), 128'(0));
    end
    reset = 1'b0;
    @(negedge clock);
    chk("sp_set", 128'(act), 128'(sv));
  endtask

  task automatic run_instr(input int kind, input bit ovf, input bit dz,
                           input int delay, input int abort_at, output bit aborted);
    outs_t o;
    bit    md, trap, dv;
    string nm;
    expq.delete(); mdq.delete();
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    case (kind)
      K_ADD:  begin opcode = 6'h00; funct = 6'h20; nm = "add";  end
      K_SUB:  begin opcode = 6'h00; funct = 6'h22; nm = "sub";  end
      K_AND:  begin opcode = 6'h00; funct = 6'h24; nm = "and";  end
      K_ADDI: begin opcode = 6'h08; nm = "addi"; end
      K_LW:   begin opcode = 6'h23; nm = "lw";   end
      K_SW:   begin opcode = 6'h2B; nm = "sw";   end
      K_BEQ:  begin opcode = 6'h04; nm = "beq";  end
      K_J:    begin opcode = 6'h02; nm = "j";    end
      K_MULT: begin opcode = 6'h00; funct = 6'h18; nm = "mult"; end
      K_DIV:  begin opcode = 6'h00; funct = 6'h1A; nm = "div";  end
      K_BADOP: begin
        nm = "badop";
        if (forced_op >= 0) opcode = 6'(forced_op);
        else while (opcode inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B})
          opcode = 6'($urandom);
      end
      default: begin
        nm = "badfn"; opcode = 6'h00;
        while (funct inside {6'h18, 6'h1A, 6'h20, 6'h22, 6'h24})
          funct = 6'($urandom);
      end
    endcase
    overflow = ovf;
    div_zero = dz;

    gen_fetch();
    gen_decode();
    case (kind)
      K_ADD, K_SUB, K_AND: begin
        o = '0; o.alu_src_a = 2'b01;
        o.alu_op = (kind == K_ADD) ? 3'b001 : (kind == K_SUB) ? 3'b010 : 3'b011;
        push(o, noise());
        trap = ovf && (kind != K_AND);
        o = '0; o.reg_dist = 3'b001; o.reg_write = !trap;
        push(o, noise());
        if (trap) gen_exc(1);
      end
      K_ADDI: begin
        o = '0; o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_op = 3'b001;
        push(o, noise());
        o = '0; o.reg_write = !ovf;
        push(o, noise());
        if (ovf) gen_exc(1);
      end
      K_LW, K_SW: begin
        o = '0; o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_op = 3'b001;
        push(o, noise());
        if (kind == K_LW) begin
          for (int i = 0; i < MW; i++) begin
            o = '0; o.mem_read = 1'b1; o.i_or_d = 1'b1;
            push(o, noise());
          end
          o = '0; o.reg_write = 1'b1; o.mem_to_reg = 4'b0001;
          push(o, noise());
        end else begin
          o = '0; o.mem_write = 1'b1; o.i_or_d = 1'b1;
          push(o, noise());
        end
      end
      K_BEQ: begin
        o = '0; o.alu_src_a = 2'b01; o.alu_op = 3'b010;
        o.pc_write_cond = 1'b1; o.pc_source = 3'b001;
        push(o, noise());
      end
      K_J: begin
        o = '0; o.pc_write = 1'b1; o.pc_source = 3'b010;
        push(o, noise());
      end
      K_MULT, K_DIV: begin
        dv = (kind == K_DIV);
        o = '0; o.md_start = 1'b1; o.div_or_mult = dv;
        push(o, noise());
        if (dv && dz) begin
          gen_exc(2);
        end else begin
          for (int j = 0; j <= delay; j++) begin
            o = '0; o.div_or_mult = dv;
            push(o, j == delay);
          end
          o = '0; o.reg_write = 1'b1; o.reg_dist = 3'b001;
          o.mem_to_reg = 4'b0011; o.div_or_mult = dv;
          push(o, noise());
        end
      end
      default: gen_exc(0);
    endcase

    aborted = 1'b0;
    for (int i = 0; expq.size() > 0; i++) begin
      @(negedge clock);
      o  = expq.pop_front();
      md = mdq.pop_front();
      chk($sformatf("%s[%0d]", nm, i), 128'(act), 128'(o));
      if (i == abort_at) begin
        reset = 1'b1; md_done = 1'b0; aborted = 1'b1;
        expq.delete(); mdq.delete();
      end else begin
        md_done = md;
      end
    end
  endtask

  initial begin
    bit ab;
    int k;
    do_reset(3);
    run_instr(K_ADD,  1'b0, 1'b0, 0, -1, ab);
    run_instr(K_ADDI, 1'b1, 1'b0, 0, -1, ab);
    run_instr(K_DIV,  1'b0, 1'b0, 33, -1, ab);
    run_instr(K_DIV,  1'b0, 1'b1, 0, -1, ab);
    forced_op = 6'h3F;
    run_instr(K_BADOP, 1'b0, 1'b0, 0, -1, ab);
    forced_op = -1;
    run_instr(K_SUB,  1'b1, 1'b0, 0, -1, ab);
    run_instr(K_AND,  1'b1, 1'b0, 0, -1, ab);
    run_instr(K_MULT, 1'b0, 1'b1, 2, -1, ab);
    run_instr(K_LW,   1'b0, 1'b0, 0, -1, ab);
    run_instr(K_SW,   1'b0, 1'b0, 0, -1, ab);
    // Reset in the middle of the mult/div wait.
    run_instr(K_DIV,  1'b0, 1'b0, 20, MW + 2 + 5, ab);
    if (ab) do_reset(2);
    // Reset in the middle of the fetch wait.
    run_instr(K_ADD,  1'b0, 1'b0, 0, 1, ab);
    if (ab) do_reset(1);
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 11));
      run_instr(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 40)), -1, ab);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
